core_mem_responder: RTL and testbench

//  Parametrised dual-port (instruction + data) memory responder for core-level benches and FPGA bring-up.

---
 rtl/core_mem_pkg.sv | 30 +++
 rtl/mem_resp_pipe.sv | 55 +++++
 rtl/core_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_core_mem_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// core_mem_pkg
//   Shared types and constants for the core memory responder.
//   - Default parameter values for core_mem_responder.
//   - mem_resp_t: one response word (error flag + data) at the default width.
//   - 16-bit Fibonacci LFSR tap mask and step function used for stall injection.

package core_mem_pkg;

  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned DEPTH_DEF      = 256;
  localparam int unsigned LATENCY_DEF    = 1;
  localparam int unsigned STARTUP_DEF    = 1;
  localparam logic [7:0]  STALL_MASK_DEF = 8'h00;
  localparam logic [15:0] LFSR_SEED_DEF  = 16'hACE1;

  // Polynomial taps 16,14,13,11 expressed for a right-shifting register:
  // they land on bits 0, 2, 3 and 5 of the current state.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef struct packed {
    logic              err;
    logic [DW_DEF-1:0] data;
  } mem_resp_t;

  // One LFSR step: feedback parity enters at the MSB, state shifts right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe
//   LATENCY-deep valid + response shift register for one responder port.
//   The last stage doubles as the output hold register: its payload is only
//   overwritten when a valid response arrives, so the data/err outputs keep
//   the last response while o_ready is low.
// Ports
//   clk      in   clock
//   reset    in   asynchronous, active-high; empties the pipe, zeroes outputs
//   i_valid  in   a request was accepted on this edge
//   i_resp   in   response snapshot taken at the accept edge
//   o_ready  out  one-cycle response strobe, LATENCY cycles after accept
//   o_resp   out  response payload, held between strobes

module mem_resp_pipe
  import core_mem_pkg::*;
#(
  parameter type         resp_t  = mem_resp_t,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_valid,
  input  resp_t i_resp,
  output logic  o_ready,
  output resp_t o_resp
);

  logic  r_vld  [LATENCY];
  resp_t r_resp [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(LATENCY); k++) begin
        r_vld[k]  <= 1'b0;
        r_resp[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) begin
        r_resp[0] <= i_resp;
      end
      for (int k = 1; k < int'(LATENCY); k++) begin
        r_vld[k] <= r_vld[k-1];
        // Payload only moves with a valid beat, which gives the hold behaviour.
        if (r_vld[k-1]) begin
          r_resp[k] <= r_resp[k-1];
        end
      end
    end
  end

  assign o_ready = r_vld[LATENCY-1];
  assign o_resp  = r_resp[LATENCY-1];

endmodule

// File: rtl/core_mem_responder.sv
// core_mem_responder
//   Dual-port (fetch + load/store) memory responder sitting on the core's
//   imem/dmem req/ready interface. Both ports share one word array. Each port
//   accepts at most one request per cycle; a response comes back LATENCY
//   cycles later through a mem_resp_pipe. Acceptance is blocked for STARTUP
//   cycles after reset and can be throttled by an LFSR-driven stall.
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   i_req, i_addr       fetch request (level) and byte address
//   i_ready, i_data,    fetch response strobe, data, bad-address flag
//   i_err
//   d_req, d_we, d_be,  data request (level), store select, byte enables,
//   d_addr, d_wdata     byte address, store data
//   d_ready, d_rdata,   data response strobe, load data (0 for stores),
//   d_err               bad-address flag
//   ld_en, ld_idx,      word preload port, works while reset is asserted
//   ld_data

module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned LATENCY    = LATENCY_DEF,
  parameter int unsigned STARTUP    = STARTUP_DEF,
  parameter logic [7:0]  STALL_MASK = STALL_MASK_DEF,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  // Fetch port
  input  logic                     i_req,
  input  logic [31:0]              i_addr,
  output logic                     i_ready,
  output logic [DW-1:0]            i_data,
  output logic                     i_err,
  // Load/store port
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [DW/8-1:0]          d_be,
  input  logic [31:0]              d_addr,
  input  logic [DW-1:0]            d_wdata,
  output logic                     d_ready,
  output logic [DW-1:0]            d_rdata,
  output logic                     d_err,
  // Preload
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DW-1:0]            ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = DW / 8;
  // Counter must hold STARTUP itself; keep at least one bit when STARTUP is 0.
  localparam int unsigned SW = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;

  // Same layout as mem_resp_t, but sized by this instance's DW.
  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } port_resp_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_mem [DEPTH];
  logic [SW-1:0] r_startup;
  logic [15:0]   r_lfsr;

  // ---------------------------------------------------------------------------
  // Accept logic
  // ---------------------------------------------------------------------------
  logic          w_open;
  logic          w_i_stall;
  logic          w_d_stall;
  logic          w_i_acc;
  logic          w_d_acc;
  logic          w_i_ok;
  logic          w_d_ok;
  logic [AW-1:0] w_i_idx;
  logic [AW-1:0] w_d_idx;
  logic          w_d_wr;

  // Reset gating matters when STARTUP is 0: no store may land while reset is high.
  assign w_open    = (r_startup == '0) && !reset;
  assign w_i_stall = |(r_lfsr[7:0] & STALL_MASK);
  assign w_d_stall = |(r_lfsr[15:8] & STALL_MASK);
  assign w_i_acc   = i_req && w_open && !w_i_stall;
  assign w_d_acc   = d_req && w_open && !w_d_stall;

  // Word aligned and every bit above the index field clear.
  assign w_i_ok  = (i_addr[1:0] == 2'b00) && (i_addr[31:AW+2] == '0);
  assign w_d_ok  = (d_addr[1:0] == 2'b00) && (d_addr[31:AW+2] == '0);
  assign w_i_idx = i_addr[AW+1:2];
  assign w_d_idx = d_addr[AW+1:2];
  assign w_d_wr  = w_d_acc && d_we && w_d_ok;

  // ---------------------------------------------------------------------------
  // Response snapshot at the accept edge. Reads see the array before any
  // same-edge store or preload, so a colliding fetch returns the old word.
  // ---------------------------------------------------------------------------
  port_resp_t w_i_resp;
  port_resp_t w_d_resp;

  always_comb begin
    w_i_resp     = '0;
    w_i_resp.err = !w_i_ok;
    if (w_i_ok) begin
      w_i_resp.data = r_mem[w_i_idx];
    end

    w_d_resp     = '0;
    w_d_resp.err = !w_d_ok;
    if (w_d_ok && !d_we) begin
      w_d_resp.data = r_mem[w_d_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Word array: no reset so contents survive a reset pulse. The store is
  // written after the preload so its enabled bytes win on a collision while
  // the preload supplies the remaining bytes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_idx] <= ld_data;
    end
    if (w_d_wr) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (d_be[b]) begin
          r_mem[w_d_idx][b*8 +: 8] <= d_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Startup counter and stall LFSR
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_startup <= SW'(STARTUP);
      r_lfsr    <= LFSR_SEED;
    end else begin
      if (r_startup != '0) begin
        r_startup <= r_startup - SW'(1);
      end
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipes
  // ---------------------------------------------------------------------------
  port_resp_t w_i_out;
  port_resp_t w_d_out;

  mem_resp_pipe #(
    .resp_t  (port_resp_t),
    .LATENCY (LATENCY)
  ) u_i_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_i_acc),
    .i_resp  (w_i_resp),
    .o_ready (i_ready),
    .o_resp  (w_i_out)
  );

  mem_resp_pipe #(
    .resp_t  (port_resp_t),
    .LATENCY (LATENCY)
  ) u_d_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_d_acc),
    .i_resp  (w_d_resp),
    .o_ready (d_ready),
    .o_resp  (w_d_out)
  );

  assign i_data  = w_i_out.data;
  assign i_err   = w_i_out.err;
  assign d_rdata = w_d_out.data;
  assign d_err   = w_d_out.err;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder. Three instances share clock and preload port:
//   u_a: LATENCY=1, STARTUP=1, no stalls   -- functional directed vectors
//   u_b: LATENCY=3, STARTUP=1, no stalls   -- pipelining and mid-flight reset
//   u_c: LATENCY=2, STARTUP=3, mask 8'hFF  -- random requests vs. scoreboard
// Inputs are driven on the falling edge, outputs sampled on the falling edge.

module tb_core_mem_responder;

  localparam int unsigned LC  = 2;
  localparam int unsigned STC = 3;

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } drv_t;

  typedef struct packed {
    logic        i_ready;
    logic [31:0] i_data;
    logic        i_err;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
  } obs_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;
  drv_t        da, db, dc;
  obs_t        oa, ob, oc;

  int          n_run  = 0;
  int          n_fail = 0;

  // Scoreboard state for u_c
  int          cyc;
  int          m_cnt;
  logic [15:0] m_lfsr;
  logic [31:0] cmem [4];
  exp_t        qi[$];
  exp_t        qd[$];
  logic [31:0] c_addrs [7] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd2, 32'd6, 32'd1024};
  logic [31:0] b_exp   [3] = '{32'h1234_5678, 32'h1122_3344, 32'h0000_0000};

  always #5 clk = ~clk;

  core_mem_responder #(.LATENCY(1), .STARTUP(1)) u_a (
    .clk(clk), .reset(rst_a),
    .i_req(da.i_req), .i_addr(da.i_addr),
    .i_ready(oa.i_ready), .i_data(oa.i_data), .i_err(oa.i_err),
    .d_req(da.d_req), .d_we(da.d_we), .d_be(da.d_be), .d_addr(da.d_addr),
    .d_wdata(da.d_wdata),
    .d_ready(oa.d_ready), .d_rdata(oa.d_rdata), .d_err(oa.d_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  core_mem_responder #(.LATENCY(3), .STARTUP(1)) u_b (
    .clk(clk), .reset(rst_b),
    .i_req(db.i_req), .i_addr(db.i_addr),
    .i_ready(ob.i_ready), .i_data(ob.i_data), .i_err(ob.i_err),
    .d_req(db.d_req), .d_we(db.d_we), .d_be(db.d_be), .d_addr(db.d_addr),
    .d_wdata(db.d_wdata),
    .d_ready(ob.d_ready), .d_rdata(ob.d_rdata), .d_err(ob.d_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  core_mem_responder #(.LATENCY(LC), .STARTUP(STC), .STALL_MASK(8'hFF)) u_c (
    .clk(clk), .reset(rst_c),
    .i_req(dc.i_req), .i_addr(dc.i_addr),
    .i_ready(oc.i_ready), .i_data(oc.i_data), .i_err(oc.i_err),
    .d_req(dc.d_req), .d_we(dc.d_we), .d_be(dc.d_be), .d_addr(dc.d_addr),
    .d_wdata(dc.d_wdata),
    .d_ready(oc.d_ready), .d_rdata(oc.d_rdata), .d_err(oc.d_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference LFSR: taps 16,14,13,11, shifting right.
  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic exp_t m_resp(input int c, input logic [31:0] addr, input logic rd);
    exp_t e;
    logic ok;
    ok     = (addr[1:0] == 2'b00) && (addr < 32'd1024);
    e.cyc  = c;
    e.err  = !ok;
    e.data = (ok && rd) ? cmem[addr[3:2]] : 32'h0;
    return e;
  endfunction

  // One u_a transaction: drive at the falling edge, accept on the next rising
  // edge, return at the following falling edge with the response visible.
  task automatic a_op(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                      input logic we, input logic [3:0] be, input logic [31:0] daddr,
                      input logic [31:0] wdata);
    da.i_req   = ireq;
    da.i_addr  = iaddr;
    da.d_req   = dreq;
    da.d_we    = we;
    da.d_be    = be;
    da.d_addr  = daddr;
    da.d_wdata = wdata;
    @(posedge clk);
    #1;
    da    = '0;
    ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic b_load(input logic [31:0] addr, output logic [31:0] data, output logic seen);
    seen      = 1'b0;
    data      = 32'h0;
    db.d_req  = 1'b1;
    db.d_we   = 1'b0;
    db.d_addr = addr;
    @(posedge clk);
    #1;
    db.d_req = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (ob.d_ready) begin
        seen = 1'b1;
        data = ob.d_rdata;
      end
    end
  endtask

  // One u_c cycle: predict accepts at the rising edge, check the scoreboard at
  // the falling edge, then drive the next request.
  task automatic c_cycle(input bit rnd);
    logic acc_i, acc_d, due_i, due_d;
    exp_t e;
    @(posedge clk);
    cyc++;
    acc_i = dc.i_req && (m_cnt == 0) && ((m_lfsr[7:0] & 8'hFF) == 8'h00);
    acc_d = dc.d_req && (m_cnt == 0) && ((m_lfsr[15:8] & 8'hFF) == 8'h00);
    if (acc_i) qi.push_back(m_resp(cyc, dc.i_addr, 1'b1));
    if (acc_d) begin
      qd.push_back(m_resp(cyc, dc.d_addr, !dc.d_we));
      if (dc.d_we && dc.d_addr[1:0] == 2'b00 && dc.d_addr < 32'd1024) begin
        for (int b = 0; b < 4; b++) begin
          if (dc.d_be[b]) cmem[dc.d_addr[3:2]][b*8 +: 8] = dc.d_wdata[b*8 +: 8];
        end
      end
    end
    if (m_cnt != 0) m_cnt--;
    m_lfsr = m_step(m_lfsr);
    @(negedge clk);
    due_i = (qi.size() > 0) && (qi[0].cyc == cyc - int'(LC - 1));
    due_d = (qd.size() > 0) && (qd[0].cyc == cyc - int'(LC - 1));
    check("c_i_ready", oc.i_ready, due_i);
    check("c_d_ready", oc.d_ready, due_d);
    if (due_i) begin
      e = qi.pop_front();
      check("c_i_data", oc.i_data, e.data);
      check("c_i_err", oc.i_err, e.err);
    end
    if (due_d) begin
      e = qd.pop_front();
      check("c_d_rdata", oc.d_rdata, e.data);
      check("c_d_err", oc.d_err, e.err);
    end
    if (rnd) begin
      dc.i_req   = ($urandom_range(3) != 0);
      dc.i_addr  = c_addrs[$urandom_range(6)];
      dc.d_req   = ($urandom_range(3) != 0);
      dc.d_we    = $urandom_range(1);
      dc.d_be    = 4'($urandom_range(15));
      dc.d_addr  = c_addrs[$urandom_range(6)];
      dc.d_wdata = $urandom;
    end else begin
      dc = '0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;
    int          pulses;

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    da = '0;
    db = '0;
    dc = '0;
    ld_en = 1'b0;
    ld_idx = 8'd0;
    ld_data = 32'h0;

    // Preload while every instance is held in reset.
    ld_en = 1'b1;
    ld_idx = 8'd0; ld_data = 32'h1234_5678; @(posedge clk); #1;
    ld_idx = 8'd1; ld_data = 32'h1122_3344; @(posedge clk); #1;
    ld_idx = 8'd2; ld_data = 32'h0000_0000; @(posedge clk); #1;
    ld_en = 1'b0;
    @(negedge clk);
    check("rst_i_ready", oa.i_ready, 1'b0);
    check("rst_i_data", oa.i_data, 32'h0);
    check("rst_d_ready", oa.d_ready, 1'b0);
    check("rst_d_rdata", oa.d_rdata, 32'h0);
    check("rst_d_err", oa.d_err, 1'b0);
    check("rst_b_d_ready", ob.d_ready, 1'b0);

    // ---- u_a: fetch held from reset release, blocked by startup for one edge
    rst_a = 1'b0;
    rst_b = 1'b0;
    da.i_req  = 1'b1;
    da.i_addr = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check("a_startup_block", oa.i_ready, 1'b0);
    @(posedge clk);
    #1;
    da.i_req = 1'b0;
    @(negedge clk);
    check("a_first_ready", oa.i_ready, 1'b1);
    check("a_first_data", oa.i_data, 32'h1234_5678);
    check("a_first_err", oa.i_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("a_hold_ready", oa.i_ready, 1'b0);
    check("a_hold_data", oa.i_data, 32'h1234_5678);

    // Byte-enable store then load.
    a_op(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'd4, 32'hDEAD_BEEF);
    check("a_st_ready", oa.d_ready, 1'b1);
    check("a_st_rdata", oa.d_rdata, 32'h0);
    check("a_st_err", oa.d_err, 1'b0);
    a_op(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd4, 32'h0);
    check("a_be_load", oa.d_rdata, 32'h1122_BEEF);
    check("a_be_err", oa.d_err, 1'b0);

    // Same-edge store and fetch of word 2: fetch sees the old word.
    a_op(1'b1, 32'd8, 1'b1, 1'b1, 4'b1111, 32'd8, 32'hAAAA_AAAA);
    check("a_rbw_ready", oa.i_ready, 1'b1);
    check("a_rbw_old", oa.i_data, 32'h0);
    check("a_rbw_st_ready", oa.d_ready, 1'b1);
    a_op(1'b1, 32'd8, 1'b0, 1'b0, 4'b0000, 32'd0, 32'h0);
    check("a_rbw_new", oa.i_data, 32'hAAAA_AAAA);

    // Bad addresses.
    a_op(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd2, 32'h0);
    check("a_mis_err", oa.d_err, 1'b1);
    check("a_mis_rdata", oa.d_rdata, 32'h0);
    a_op(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd1024, 32'h0);
    check("a_oor_err", oa.d_err, 1'b1);
    check("a_oor_rdata", oa.d_rdata, 32'h0);
    a_op(1'b1, 32'd6, 1'b0, 1'b0, 4'b0000, 32'd0, 32'h0);
    check("a_i_mis_err", oa.i_err, 1'b1);
    check("a_i_mis_data", oa.i_data, 32'h0);
    a_op(1'b0, 32'd0, 1'b1, 1'b1, 4'b1111, 32'd1024, 32'h5555_5555);
    check("a_oor_st_err", oa.d_err, 1'b1);
    a_op(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd0, 32'h0);
    check("a_no_alias", oa.d_rdata, 32'h1234_5678);

    // Preload and store to word 3 on the same edge.
    ld_en = 1'b1;
    ld_idx = 8'd3;
    ld_data = 32'h1111_1111;
    a_op(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'd12, 32'h0000_BBBB);
    a_op(1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'd12, 32'h0);
    check("a_ld_st_merge", oa.d_rdata, 32'h1111_BBBB);

    // ---- u_b: three back-to-back loads with LATENCY=3
    db.d_req  = 1'b1;
    db.d_we   = 1'b0;
    db.d_addr = 32'd0;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) db.d_addr = 32'd4;
      if (j == 2) db.d_addr = 32'd8;
      if (j == 3) db.d_req = 1'b0;
      @(negedge clk);
      check($sformatf("b_ready_%0d", j), ob.d_ready, (j >= 3 && j <= 5));
      if (j >= 3 && j <= 5) check($sformatf("b_data_%0d", j), ob.d_rdata, b_exp[j-3]);
    end

    // Two stores in flight, then reset: no pulses, stores kept.
    db.d_req   = 1'b1;
    db.d_we    = 1'b1;
    db.d_be    = 4'b1111;
    db.d_addr  = 32'd16;
    db.d_wdata = 32'hDDDD_0001;
    @(posedge clk);
    #1;
    db.d_addr  = 32'd20;
    db.d_wdata = 32'hDDDD_0002;
    @(posedge clk);
    #1;
    db = '0;
    rst_b = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ob.d_ready) pulses++;
      if (k == 2) rst_b = 1'b0;
    end
    check("b_rst_no_pulse", pulses, 0);
    b_load(32'd16, rd, seen);
    check("b_keep0_seen", seen, 1'b1);
    check("b_keep0_data", rd, 32'hDDDD_0001);
    b_load(32'd20, rd, seen);
    check("b_keep1_seen", seen, 1'b1);
    check("b_keep1_data", rd, 32'hDDDD_0002);

    // ---- u_c: random requests against the stall scoreboard
    @(negedge clk);
    rst_c = 1'b0;
    m_cnt = STC;
    m_lfsr = 16'hACE1;
    cyc = 0;
    cmem = '{32'h1234_5678, 32'h1122_3344, 32'h0000_0000, 32'h1111_1111};
    dc.i_req = 1'b1;
    dc.i_addr = 32'd0;
    for (int n = 0; n < 1000; n++) c_cycle(1'b1);
    for (int n = 0; n < 6; n++) c_cycle(1'b0);
    check("c_i_drained", qi.size(), 0);
    check("c_d_drained", qd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
